// File: rtl/hdmi_pkg.sv
// Shared constants, enums and aux-class helpers for the HDMI receive period tracker.
package hdmi_pkg;

    localparam logic [6:0] AUX_GUARD_B    = 7'h41;
    localparam logic [6:0] AUX_GUARD_A    = 7'h68;
    localparam logic [6:0] AUX_CTL_MASK   = 7'h70;
    localparam logic [6:0] AUX_CTL_VAL    = 7'h10;
    localparam logic [6:0] AUX_TERC4_MASK = 7'h20;

    localparam logic [1:0] PRE_CTL1     = 2'b01;
    localparam logic [1:0] PRE_VID_CTL2 = 2'b00;
    localparam logic [1:0] PRE_ISL_CTL2 = 2'b01;

    localparam int PKT_LEN = 32;

    typedef enum logic [2:0] {
        ST_CTL    = 3'd0,
        ST_VGUARD = 3'd1,
        ST_VIDEO  = 3'd2,
        ST_DLEAD  = 3'd3,
        ST_ISLAND = 3'd4,
        ST_DTRAIL = 3'd5
    } state_e;

    typedef enum logic [1:0] {
        PRE_NONE   = 2'd0,
        PRE_VIDEO  = 2'd1,
        PRE_ISLAND = 2'd2
    } pre_e;

    function automatic logic is_ctl(input logic [6:0] aux);
        return (aux & AUX_CTL_MASK) == AUX_CTL_VAL;
    endfunction

    function automatic logic is_terc4(input logic [6:0] aux);
        return (aux & AUX_TERC4_MASK) != 7'h00;
    endfunction

endpackage

// File: rtl/hdmi_preamble_detect.sv
// Classifies each character as video/island/no preamble and counts identical
// consecutive preamble characters, saturating at P_PREAMBLE.
module hdmi_preamble_detect
    import hdmi_pkg::*;
#(
    parameter int P_PREAMBLE = 8
) (
    input  logic       i_clk,
    input  logic       i_reset_n,
    input  logic [6:0] i_aux0,
    input  logic [6:0] i_aux1,
    input  logic [6:0] i_aux2,
    input  logic [1:0] i_ctl1,
    input  logic [1:0] i_ctl2,
    output logic       o_video_ready,
    output logic       o_island_ready
);

    localparam int              CW      = $clog2(P_PREAMBLE + 1);
    localparam logic [CW-1:0]   PRE_MAX = CW'(P_PREAMBLE);

    pre_e          type_q, type_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          all_ctl_s;

    // Classify the current character and advance the run counter.
    always_comb begin
        type_d    = PRE_NONE;
        cnt_d     = cnt_q;
        all_ctl_s = is_ctl(i_aux0) && is_ctl(i_aux1) && is_ctl(i_aux2);
        if (all_ctl_s && (i_ctl1 == PRE_CTL1) && (i_ctl2 == PRE_VID_CTL2)) begin
            type_d = PRE_VIDEO;
        end else if (all_ctl_s && (i_ctl1 == PRE_CTL1) && (i_ctl2 == PRE_ISL_CTL2)) begin
            type_d = PRE_ISLAND;
        end else begin
            type_d = PRE_NONE;
        end
        if (type_d == PRE_NONE) begin
            cnt_d = {CW{1'b0}};
        end else if (type_d != type_q) begin
            cnt_d = CW'(1);
        end else if (cnt_q == PRE_MAX) begin
            cnt_d = cnt_q;
        end else begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    // Preamble run state register.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            type_q <= PRE_NONE;
            cnt_q  <= {CW{1'b0}};
        end else begin
            type_q <= type_d;
            cnt_q  <= cnt_d;
        end
    end

    assign o_video_ready  = (type_q == PRE_VIDEO)  && (cnt_q == PRE_MAX);
    assign o_island_ready = (type_q == PRE_ISLAND) && (cnt_q == PRE_MAX);

endmodule

// File: rtl/hdmi_period_tracker.sv
// HDMI receive period sequencer: tracks control/video/data-island periods and
// emits registered pixel, sync and TERC4 nibble streams with error pulses.
module hdmi_period_tracker
    import hdmi_pkg::*;
#(
    parameter int P_PREAMBLE = 8,
    parameter int P_MAX_PKTS = 18
) (
    input  logic        i_clk,
    input  logic        i_reset_n,
    input  logic [6:0]  i_aux0,
    input  logic [6:0]  i_aux1,
    input  logic [6:0]  i_aux2,
    input  logic [1:0]  i_ctl0,
    input  logic [1:0]  i_ctl1,
    input  logic [1:0]  i_ctl2,
    input  logic [7:0]  i_pix0,
    input  logic [7:0]  i_pix1,
    input  logic [7:0]  i_pix2,
    output logic        o_de,
    output logic [23:0] o_pix,
    output logic        o_hsync,
    output logic        o_vsync,
    output logic        o_isl_valid,
    output logic [11:0] o_isl_data,
    output logic        o_pkt_start,
    output logic        o_err
);

    localparam int            CCW     = $clog2(PKT_LEN);
    localparam int            PW      = $clog2(P_MAX_PKTS + 1);
    localparam logic [PW-1:0] PKT_MAX = PW'(P_MAX_PKTS);

    state_e         state_q, state_d;
    logic [CCW-1:0] char_cnt_q, char_cnt_d;
    logic [PW-1:0]  pkt_cnt_q, pkt_cnt_d;
    logic           de_q, de_d, hsync_q, hsync_d, vsync_q, vsync_d;
    logic           isl_valid_q, isl_valid_d, pkt_start_q, pkt_start_d, err_q, err_d;
    logic [23:0]    pix_q, pix_d;
    logic [11:0]    isl_data_q, isl_data_d;
    logic           video_ready_s, island_ready_s;
    logic           all_ctl_s, all_terc4_s, vid_guard_s, isl_guard_s, trail_s, pkt_first_s;

    hdmi_preamble_detect #(.P_PREAMBLE(P_PREAMBLE)) u_pre (
        .i_clk          (i_clk),
        .i_reset_n      (i_reset_n),
        .i_aux0         (i_aux0),
        .i_aux1         (i_aux1),
        .i_aux2         (i_aux2),
        .i_ctl1         (i_ctl1),
        .i_ctl2         (i_ctl2),
        .o_video_ready  (video_ready_s),
        .o_island_ready (island_ready_s)
    );

    assign all_ctl_s   = is_ctl(i_aux0) && is_ctl(i_aux1) && is_ctl(i_aux2);
    assign all_terc4_s = is_terc4(i_aux0) && is_terc4(i_aux1) && is_terc4(i_aux2);
    assign vid_guard_s = (i_aux0 == AUX_GUARD_A) && (i_aux1 == AUX_GUARD_B) && (i_aux2 == AUX_GUARD_A);
    assign trail_s     = (i_aux1 == AUX_GUARD_B) && (i_aux2 == AUX_GUARD_B);
    assign isl_guard_s = trail_s && is_terc4(i_aux0);
    assign pkt_first_s = (char_cnt_q == {CCW{1'b0}});

    // Period state machine and next values of all registered outputs.
    always_comb begin
        state_d     = state_q;
        char_cnt_d  = char_cnt_q;
        pkt_cnt_d   = pkt_cnt_q;
        de_d        = 1'b0;
        pix_d       = pix_q;
        hsync_d     = hsync_q;
        vsync_d     = vsync_q;
        isl_valid_d = 1'b0;
        isl_data_d  = isl_data_q;
        pkt_start_d = 1'b0;
        err_d       = 1'b0;
        case (state_q)
            ST_CTL: begin
                if (vid_guard_s) begin
                    if (video_ready_s) begin
                        state_d = ST_VGUARD;
                    end else begin
                        err_d = 1'b1;
                    end
                end else if (isl_guard_s) begin
                    if (island_ready_s) begin
                        state_d = ST_DLEAD;
                        hsync_d = i_aux0[0];
                        vsync_d = i_aux0[1];
                    end else begin
                        err_d = 1'b1;
                    end
                end else if (all_ctl_s) begin
                    hsync_d = i_ctl0[0];
                    vsync_d = i_ctl0[1];
                end else begin
                    state_d = ST_CTL;
                end
            end
            ST_VGUARD: begin
                if (vid_guard_s) begin
                    state_d = ST_VIDEO;
                end else begin
                    state_d = ST_CTL;
                    err_d   = 1'b1;
                end
            end
            ST_VIDEO: begin
                if (all_ctl_s) begin
                    state_d = ST_CTL;
                    hsync_d = i_ctl0[0];
                    vsync_d = i_ctl0[1];
                end else begin
                    de_d  = 1'b1;
                    pix_d = {i_pix2, i_pix1, i_pix0};
                end
            end
            ST_DLEAD: begin
                if (isl_guard_s) begin
                    state_d    = ST_ISLAND;
                    char_cnt_d = {CCW{1'b0}};
                    pkt_cnt_d  = {PW{1'b0}};
                    hsync_d    = i_aux0[0];
                    vsync_d    = i_aux0[1];
                end else begin
                    state_d = ST_CTL;
                    err_d   = 1'b1;
                end
            end
            ST_ISLAND: begin
                // A guard at a packet boundary closes the island instead of opening a packet.
                if (pkt_first_s && trail_s) begin
                    state_d = ST_DTRAIL;
                    hsync_d = i_aux0[0];
                    vsync_d = i_aux0[1];
                end else if (!all_terc4_s || (pkt_first_s && (pkt_cnt_q == PKT_MAX))) begin
                    state_d = ST_CTL;
                    err_d   = 1'b1;
                end else begin
                    isl_valid_d = 1'b1;
                    isl_data_d  = {i_aux2[3:0], i_aux1[3:0], i_aux0[3:0]};
                    pkt_start_d = pkt_first_s;
                    char_cnt_d  = char_cnt_q + CCW'(1);
                    hsync_d     = i_aux0[0];
                    vsync_d     = i_aux0[1];
                    if (pkt_first_s) begin
                        pkt_cnt_d = pkt_cnt_q + PW'(1);
                    end else begin
                        pkt_cnt_d = pkt_cnt_q;
                    end
                end
            end
            ST_DTRAIL: begin
                state_d = ST_CTL;
                if (trail_s) begin
                    hsync_d = i_aux0[0];
                    vsync_d = i_aux0[1];
                end else begin
                    err_d = 1'b1;
                end
            end
            default: begin
                state_d = ST_CTL;
            end
        endcase
    end

    // State, counters and output registers.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state_q     <= ST_CTL;
            char_cnt_q  <= {CCW{1'b0}};
            pkt_cnt_q   <= {PW{1'b0}};
            de_q        <= 1'b0;
            pix_q       <= 24'h000000;
            hsync_q     <= 1'b0;
            vsync_q     <= 1'b0;
            isl_valid_q <= 1'b0;
            isl_data_q  <= 12'h000;
            pkt_start_q <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            char_cnt_q  <= char_cnt_d;
            pkt_cnt_q   <= pkt_cnt_d;
            de_q        <= de_d;
            pix_q       <= pix_d;
            hsync_q     <= hsync_d;
            vsync_q     <= vsync_d;
            isl_valid_q <= isl_valid_d;
            isl_data_q  <= isl_data_d;
            pkt_start_q <= pkt_start_d;
            err_q       <= err_d;
        end
    end

    assign o_de        = de_q;
    assign o_pix       = pix_q;
    assign o_hsync     = hsync_q;
    assign o_vsync     = vsync_q;
    assign o_isl_valid = isl_valid_q;
    assign o_isl_data  = isl_data_q;
    assign o_pkt_start = pkt_start_q;
    assign o_err       = err_q;

endmodule

// File: doc/hdmi_period_tracker.md
# hdmi_period_tracker

Sequencer that sits directly behind the three per-channel TMDS decoders in the HDMI receive path. It classifies every character time as control, video or data-island. It enforces the preamble/guard-band sequencing, and it emits registered pixel, sync and TERC4 packet-nibble streams. The frame timing recovery logic and the data-island packet parser consume its outputs.

## Interface
- `P_PREAMBLE`, default 8: minimum run of identical preamble control characters required before a guard band is accepted.
- `P_MAX_PKTS`, default 18: maximum 32-character packets per data island.
- `i_clk` input 1: pixel clock.
- `i_reset_n` input 1: reset. One clock; reset is asynchronous and active-low.
- `i_aux0`, `i_aux1`, `i_aux2` input 7 each: per-channel decoder aux class/value code.
- `i_ctl0`, `i_ctl1`, `i_ctl2` input 2 each: per-channel decoded control bits.
- `i_pix0`, `i_pix1`, `i_pix2` input 8 each: per-channel decoded pixel byte.
- `o_de` output 1: video pixel valid.
- `o_pix` output 24: {ch2, ch1, ch0} pixel bytes.
- `o_hsync`, `o_vsync` output 1 each: recovered syncs.
- `o_isl_valid` output 1: data-island character valid.
- `o_isl_data` output 12: {ch2, ch1, ch0} TERC4 nibbles.
- `o_pkt_start` output 1: first character of a 32-character packet.
- `o_err` output 1: one-cycle sequencing violation pulse.

## Operation
- Aux classes:
  - Control: `aux[6:4]==3'b001`.
  - TERC4: `aux[5]==1`; the nibble is `aux[3:0]`. The code `7'h68` is TERC4 value 8 and also a guard character.
  - Guard-B: `aux==7'h41`.
- Video preamble: `i_ctl1==2'b01` and `i_ctl2==2'b00`, with all channels Control.
- Island preamble: `i_ctl1==2'b01` and `i_ctl2==2'b01`, with all channels Control.
- Preamble counter:
  - Saturates at `P_PREAMBLE`.
  - Increments while the same preamble type repeats.
  - Restarts at 1 on a type change and at 0 on a non-preamble character.
- State machine:
  - **CTL**: `o_hsync`/`o_vsync` follow `i_ctl0[0]`/`i_ctl0[1]`.
    - Video guard (ch0 and ch2 `7'h68`, ch1 `7'h41`) with the counter at `P_PREAMBLE` of video type → **VGUARD**.
    - Island guard (ch1 and ch2 `7'h41`, ch0 TERC4) with the counter at `P_PREAMBLE` of island type → **DLEAD**.
    - A guard character without a full preamble → `o_err`, stay in CTL.
  - **VGUARD**: exactly 2 guard characters. A matching 2nd character → **VIDEO**; a mismatch → `o_err` and CTL.
  - **VIDEO**: every non-all-Control character gives `o_de=1` and `o_pix` = inputs.
    - All three channels Control → CTL. That character updates the syncs and seeds the preamble counter.
    - Syncs are held during VIDEO.
  - **DLEAD**: 2 island guard characters; ch0 nibble bits [1:0] update the syncs. After the 2nd → **ISLAND**; a mismatch → `o_err` and CTL.
  - **ISLAND**:
    - Every channel must be TERC4, otherwise `o_err` and CTL.
    - Each character: `o_isl_valid=1`, `o_isl_data` = nibbles, syncs from the ch0 nibble.
    - A 5-bit character counter wraps every 32 characters; `o_pkt_start=1` when the counter is 0.
    - At counter 0:
      - ch1 and ch2 `7'h41` → **DTRAIL**; that character is not a packet character.
      - Otherwise a new packet begins. If this would be packet number `P_MAX_PKTS+1` → `o_err` and CTL.
  - **DTRAIL**: 2 trailing guard characters, then CTL; a mismatch → `o_err` and CTL.
- `o_err` pulses for one cycle and is not sticky. An error character never asserts `o_de` or `o_isl_valid`.

## Timing
- All outputs are registered: inputs at cycle N appear on the outputs at N+1, and there is no other latency.
- Reset values: state CTL, all counters 0, `o_de` 0, `o_pix` 0, `o_hsync` 0, `o_vsync` 0, `o_isl_valid` 0, `o_isl_data` 0, `o_pkt_start` 0, `o_err` 0.
- Reset asserted mid-period drops all outputs asynchronously. After release, the block requires a fresh full preamble.
- `o_de` and `o_isl_valid` are never both 1.
- The first `o_de` follows the 2nd video guard character by 1 cycle.

## Structure
- Shared package `hdmi_pkg`:
  - aux constants: `AUX_GUARD_B=7'h41`, `AUX_GUARD_A=7'h68`.
  - class masks.
  - preamble ctl codes.
  - state enum.
  - `PKT_LEN=32`.
- One sub-module, `hdmi_preamble_detect`: preamble type classifier plus saturating run counter, feeding the top FSM.

## Test plan
- 10 video-preamble characters, 2 video guards, 4 pixel characters `24'h123456`, then control with `i_ctl0=2'b01` → `o_de` high for 4 cycles with `o_pix=24'h123456`, then `o_hsync=1`.
- 7 video-preamble characters then a video guard → `o_err` pulse, `o_de` stays 0.
- 8 island-preamble characters, 2 island guards, 64 TERC4 characters, 2 trailing guards → `o_isl_valid` for 64 cycles, `o_pkt_start` at characters 0 and 32, no `o_err`.
- An island containing a Control character at packet character 5 → `o_err`, state CTL, `o_isl_valid` 0 from then on.
- Island with 19 packets and `P_MAX_PKTS=18` → `o_err` at the start of the 19th packet.
- Assert `i_reset_n=0` mid-VIDEO → `o_de=0` immediately; after release, pixel characters give no `o_de` until a new preamble and guard.
